// File: rtl/yv_read_scheduler.sv
// Sweep sequencer and V SRAM port arbiter for the Jacobi Y/V read path.
// Walks Y column-info groups and grants up to two lanes per V SRAM per issue cycle.
module yv_read_scheduler #(
  parameter int Y_BASE = 63,
  parameter int Y_ROWS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        fifo_ready,
  input  logic [15:0] y_col_info_0,
  input  logic [15:0] y_col_info_1,
  input  logic [15:0] y_col_info_2,
  input  logic [15:0] y_col_info_3,
  output logic [10:0] y_addr,
  output logic        y_rd_en,
  output logic [35:0] sram_addr_port1,
  output logic [35:0] sram_addr_port2,
  output logic [3:0]  sram_en_port1,
  output logic [3:0]  sram_en_port2,
  output logic [3:0]  lane_issue,
  output logic [11:0] lane_route,
  output logic [3:0]  lane_newrow,
  output logic        group_last,
  output logic        busy,
  output logic        sweep_done,
  output logic        vsram_bank
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_DONE
  } state_t;

  localparam logic [10:0] Y_BASE_L = 11'(Y_BASE);
  localparam logic [10:0] LAST_ROW = 11'(Y_ROWS - 1);

  state_t      state_q, state_d;
  logic [10:0] row_q, row_d;
  logic        bank_q, bank_d;
  logic [3:0]  pending_q, pending_d;
  logic [3:0]  newrow_q, newrow_d;
  logic        first_q, first_d;
  // Per lane: {col[9:2], sram[1:0]}; the rest of the entry is consumed at LOAD.
  logic [9:0]  lane_q [4];

  logic [15:0] col_in [4];
  logic [3:0]  newrow_in;
  logic [1:0]  sel;
  logic        unused_col_bits;

  assign col_in[0] = y_col_info_0;
  assign col_in[1] = y_col_info_1;
  assign col_in[2] = y_col_info_2;
  assign col_in[3] = y_col_info_3;

  assign unused_col_bits = ^{y_col_info_0[12:10], y_col_info_1[12:10],
                             y_col_info_2[12:10], y_col_info_3[12:10]};

  always_comb begin
    for (int i = 0; i < 4; i++) newrow_in[i] = &col_in[i][15:13];
  end

  assign busy       = (state_q != S_IDLE);
  assign vsram_bank = bank_q;

  always_comb begin
    // NOTE: every comb output and next-state gets a default first, so no path can infer a latch.
    state_d         = state_q;
    row_d           = row_q;
    bank_d          = bank_q;
    pending_d       = pending_q;
    newrow_d        = newrow_q;
    first_d         = first_q;
    sel             = '0;
    y_addr          = '0;
    y_rd_en         = 1'b0;
    sram_addr_port1 = '0;
    sram_addr_port2 = '0;
    sram_en_port1   = '0;
    sram_en_port2   = '0;
    lane_issue      = '0;
    lane_route      = '0;
    lane_newrow     = '0;
    group_last      = 1'b0;
    sweep_done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          row_d   = '0;
        end
      end
      S_FETCH: begin
        y_addr  = Y_BASE_L + row_q;
        y_rd_en = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        pending_d = ~newrow_in;
        newrow_d  = newrow_in;
        first_d   = 1'b1;
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        if (fifo_ready) begin
          // Lower lanes win; a lane takes port1 of its SRAM, then port2, else waits.
          for (int i = 0; i < 4; i++) begin
            if (pending_q[i]) begin
              sel = lane_q[i][1:0];
              if (!sram_en_port1[sel]) begin
                sram_en_port1[sel]            = 1'b1;
                sram_addr_port1[9*sel +: 9]   = {bank_q, lane_q[i][9:2]};
                lane_issue[i]                 = 1'b1;
                lane_route[3*i +: 3]          = {1'b0, sel};
              end else if (!sram_en_port2[sel]) begin
                sram_en_port2[sel]            = 1'b1;
                sram_addr_port2[9*sel +: 9]   = {bank_q, lane_q[i][9:2]};
                lane_issue[i]                 = 1'b1;
                lane_route[3*i +: 3]          = {1'b1, sel};
              end
            end
          end
          pending_d   = pending_q & ~lane_issue;
          lane_newrow = first_q ? newrow_q : 4'b0000;
          first_d     = 1'b0;
          if (pending_d == 4'b0000) begin
            group_last = 1'b1;
            if (row_q == LAST_ROW) begin
              state_d = S_DONE;
              bank_d  = ~bank_q;
            end else begin
              row_d   = row_q + 11'd1;
              state_d = S_FETCH;
            end
          end
        end
      end
      S_DONE: begin
        sweep_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      bank_q    <= 1'b0;
      pending_q <= '0;
      newrow_q  <= '0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      bank_q    <= bank_d;
      pending_q <= pending_d;
      newrow_q  <= newrow_d;
      first_q   <= first_d;
    end
  end

  // NOTE: the lane array is four small flops, so it is reset like any other register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) lane_q[i] <= '0;
    end else if (state_q == S_LOAD) begin
      for (int i = 0; i < 4; i++) lane_q[i] <= col_in[i][9:0];
    end
  end

endmodule

// File: tb/tb_yv_read_scheduler.sv
// Bench for yv_read_scheduler: Y SRAM model, queue-based sweep model, per-cycle compare.
// Directed groups pin the model with literal values; random sweeps cover the rest.
module tb_yv_read_scheduler;

  localparam int Y_BASE = 63;
  localparam int Y_ROWS = 2;

  logic        clock, reset, start, fifo_ready;
  logic [15:0] y_col_info_0, y_col_info_1, y_col_info_2, y_col_info_3;
  logic [10:0] y_addr;
  logic        y_rd_en;
  logic [35:0] sram_addr_port1, sram_addr_port2;
  logic [3:0]  sram_en_port1, sram_en_port2, lane_issue, lane_newrow;
  logic [11:0] lane_route;
  logic        group_last, busy, sweep_done, vsram_bank;

  yv_read_scheduler #(.Y_BASE(Y_BASE), .Y_ROWS(Y_ROWS)) dut (
    .clock(clock), .reset(reset), .start(start), .fifo_ready(fifo_ready),
    .y_col_info_0(y_col_info_0), .y_col_info_1(y_col_info_1),
    .y_col_info_2(y_col_info_2), .y_col_info_3(y_col_info_3),
    .y_addr(y_addr), .y_rd_en(y_rd_en),
    .sram_addr_port1(sram_addr_port1), .sram_addr_port2(sram_addr_port2),
    .sram_en_port1(sram_en_port1), .sram_en_port2(sram_en_port2),
    .lane_issue(lane_issue), .lane_route(lane_route), .lane_newrow(lane_newrow),
    .group_last(group_last), .busy(busy), .sweep_done(sweep_done), .vsram_bank(vsram_bank)
  );

  typedef struct packed {
    logic [10:0] y_addr;
    logic        y_rd_en;
    logic [35:0] a1;
    logic [35:0] a2;
    logic [3:0]  en1;
    logic [3:0]  en2;
    logic [3:0]  issue;
    logic [11:0] route;
    logic [3:0]  newrow;
    logic        group_last;
    logic        busy;
    logic        sweep_done;
    logic        bank;
  } out_t;

  typedef struct {
    bit   is_issue;
    out_t o;
  } step_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] ymem [2048];
  logic [63:0] ydata;
  step_t       q[$];
  logic        mbank;
  out_t        exp_o;
  bit          exp_valid = 0;
  out_t        act;

  assign act = {y_addr, y_rd_en, sram_addr_port1, sram_addr_port2, sram_en_port1,
                sram_en_port2, lane_issue, lane_route, lane_newrow, group_last,
                busy, sweep_done, vsram_bank};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Y SRAM: registered read, data valid the cycle after the strobe.
  always @(posedge clock) if (y_rd_en) ydata <= ymem[y_addr];
  assign y_col_info_0 = ydata[15:0];
  assign y_col_info_1 = ydata[31:16];
  assign y_col_info_2 = ydata[47:32];
  assign y_col_info_3 = ydata[63:48];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h required %h", name, $time, got, want);
    end
  endtask

  function automatic out_t quiet(input logic b, input logic bank);
    out_t o;
    o      = '0;
    o.busy = b;
    o.bank = bank;
    return o;
  endfunction

  // Expected cycle list for a whole sweep, built from the Y memory as seen at start.
  task automatic push_sweep();
    step_t       st;
    logic [63:0] row;
    logic [3:0]  pend, nr;
    int          cnt[4];
    bit          first;
    logic [1:0]  s;
    logic [15:0] c;
    for (int r = 0; r < Y_ROWS; r++) begin
      st.is_issue  = 0;
      st.o         = quiet(1'b1, mbank);
      st.o.y_addr  = 11'(Y_BASE + r);
      st.o.y_rd_en = 1'b1;
      q.push_back(st);
      st.o = quiet(1'b1, mbank);
      q.push_back(st);
      row = ymem[Y_BASE + r];
      for (int i = 0; i < 4; i++) nr[i] = &row[16*i+13 +: 3];
      pend  = ~nr;
      first = 1;
      do begin
        st.is_issue = 1;
        st.o        = quiet(1'b1, mbank);
        cnt         = '{0, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
          if (pend[i]) begin
            c = row[16*i +: 16];
            s = c[1:0];
            if (cnt[s] < 2) begin
              if (cnt[s] == 0) begin
                st.o.en1[s]      = 1'b1;
                st.o.a1[9*s +: 9] = {mbank, c[9:2]};
              end else begin
                st.o.en2[s]      = 1'b1;
                st.o.a2[9*s +: 9] = {mbank, c[9:2]};
              end
              st.o.issue[i]         = 1'b1;
              st.o.route[3*i +: 3]  = {(cnt[s] == 1), s};
              cnt[s]++;
              pend[i] = 1'b0;
            end
          end
        end
        if (first) st.o.newrow = nr;
        first           = 0;
        st.o.group_last = (pend == 4'b0000);
        q.push_back(st);
      end while (pend != 4'b0000);
    end
    st.is_issue     = 0;
    st.o            = quiet(1'b1, ~mbank);
    st.o.sweep_done = 1'b1;
    q.push_back(st);
  endtask

  // Model: evaluated after inputs settle each cycle.
  initial begin
    mbank = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      if (reset) begin
        q.delete();
        mbank = 1'b0;
        exp_o = '0;
      end else if (q.size() == 0) begin
        exp_o = quiet(1'b0, mbank);
        if (start) push_sweep();
      end else if (q[0].is_issue && !fifo_ready) begin
        exp_o = quiet(1'b1, mbank);
      end else begin
        exp_o = q[0].o;
        mbank = q[0].o.bank;
        void'(q.pop_front());
      end
      exp_valid = 1;
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (exp_valid) check("outputs", 128'(act), 128'(exp_o));
    end
  end

  task automatic step(input bit st, input bit fr);
    @(posedge clock);
    #1;
    start      = st;
    fifo_ready = fr;
    @(negedge clock);
  endtask

  task automatic run_until_idle(input bit rnd);
    int n;
    n = 0;
    do begin
      if (rnd) step(($urandom_range(7) == 0), ($urandom_range(9) < 7));
      else     step(1'b0, 1'b1);
      n++;
    end while ((busy || start) && n < 300);
    if (n >= 300) check("idle_timeout", 128'(n), 128'(0));
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    fifo_ready = 1'b1;
    for (int a = 0; a < 2048; a++) ymem[a] = '0;
    @(negedge clock);
    check("reset_state", 128'(act), 128'(0));
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);

    // Sweep 1, bank 0: distinct SRAMs, then full conflict on SRAM 2.
    ymem[63] = {16'h0023, 16'h001E, 16'h0019, 16'h0014};
    ymem[64] = {16'h0012, 16'h000E, 16'h000A, 16'h0006};
    step(1, 1);
    step(0, 1);
    check("fetch_addr0", 128'({y_rd_en, y_addr}), 128'({1'b1, 11'd63}));
    step(0, 1);
    step(0, 1);
    check("dist_en1", 128'(sram_en_port1), 128'(4'b1111));
    check("dist_addr1", 128'(sram_addr_port1), 128'({9'd8, 9'd7, 9'd6, 9'd5}));
    check("dist_last", 128'({group_last, sram_en_port2}), 128'({1'b1, 4'b0000}));
    step(0, 1);
    check("fetch_addr1", 128'({y_rd_en, y_addr}), 128'({1'b1, 11'd64}));
    step(0, 1);
    step(0, 1);
    check("conf1_issue", 128'({lane_issue, sram_en_port1, sram_en_port2, group_last}),
          128'({4'b0011, 4'b0100, 4'b0100, 1'b0}));
    check("conf1_route", 128'(lane_route), 128'(12'h032));
    check("conf1_addr", 128'({sram_addr_port1, sram_addr_port2}),
          128'({36'd1 << 18, 36'd2 << 18}));
    step(1, 1);
    check("conf2_issue", 128'({lane_issue, group_last, lane_route}),
          128'({4'b1100, 1'b1, 12'hC80}));
    step(1, 1);
    check("done_pulse", 128'({sweep_done, vsram_bank, busy}), 128'({1'b1, 1'b1, 1'b1}));
    step(0, 1);
    check("idle_after", 128'({busy, vsram_bank, sweep_done}), 128'({1'b0, 1'b1, 1'b0}));
    step(0, 1);
    check("start_at_done_ignored", 128'(busy), 128'(0));

    // Sweep 2, bank 1: newrow lane, then conflict with back-pressure.
    ymem[63] = {16'h0007, 16'h000A, 16'hE000, 16'h0004};
    ymem[64] = {16'h0022, 16'h001E, 16'h001A, 16'h0016};
    step(1, 1);
    step(0, 1);
    step(0, 1);
    step(0, 1);
    check("nr_flags", 128'({lane_newrow, lane_issue, group_last}),
          128'({4'b0010, 4'b1101, 1'b1}));
    check("nr_addr", 128'(sram_addr_port1), 128'({9'h101, 9'h102, 9'h000, 9'h101}));
    step(0, 1);
    step(0, 1);
    step(0, 1);
    check("bp_first", 128'({lane_issue, sram_addr_port1}), 128'({4'b0011, 9'h0, 9'h105, 18'h0}));
    for (int k = 0; k < 3; k++) begin
      step(0, 0);
      check("bp_stall", 128'({lane_issue, sram_en_port1, sram_en_port2, group_last, lane_newrow}),
            128'(0));
    end
    step(0, 1);
    check("bp_resume", 128'({lane_issue, group_last, sram_addr_port1, sram_addr_port2}),
          128'({4'b1100, 1'b1, 9'h0, 9'h107, 18'h0, 9'h0, 9'h108, 18'h0}));
    step(0, 1);
    check("done2_bank", 128'({sweep_done, vsram_bank}), 128'({1'b1, 1'b0}));
    step(0, 1);

    // Sweep 3, bank 0: all-newrow group, then reset inside a conflict group.
    ymem[63] = {4{16'hE000}};
    ymem[64] = {16'h0012, 16'h000E, 16'h000A, 16'h0006};
    step(1, 1);
    step(0, 1);
    step(0, 1);
    step(0, 1);
    check("allnr", 128'({lane_newrow, lane_issue, sram_en_port1, sram_en_port2, group_last}),
          128'({4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1}));
    step(0, 1);
    check("allnr_next_fetch", 128'({y_rd_en, y_addr}), 128'({1'b1, 11'd64}));
    step(0, 1);
    step(0, 1);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("reset_mid", 128'(act), 128'(0));
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    step(1, 1);
    step(0, 1);
    check("restart_addr", 128'({y_rd_en, y_addr, vsram_bank}), 128'({1'b1, 11'd63, 1'b0}));
    run_until_idle(0);

    // Random sweeps with random back-pressure and stray start pulses.
    for (int sw = 0; sw < 40; sw++) begin
      for (int r = 0; r < Y_ROWS; r++) begin
        for (int l = 0; l < 4; l++) begin
          logic [15:0] c;
          c = 16'($urandom);
          if ($urandom_range(4) == 0) c[15:13] = 3'b111;
          ymem[Y_BASE + r][16*l +: 16] = c;
        end
      end
      step(1, ($urandom_range(9) < 7));
      run_until_idle(1);
    end

    step(0, 1);
    step(0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/yv_read_scheduler.md
# yv_read_scheduler

Sweep-level sequencer and port arbiter for the Jacobi Y/V read path. On `start` it walks the Y column-info SRAM one 4-entry group per address. For each group it decodes the target V SRAM and column of every lane and grants the lanes onto the two read ports of each of the four V SRAMs. When more than two lanes hit the same SRAM, it serialises them over extra cycles and stalls on downstream FIFO back-pressure. It owns the V ping-pong bank bit and flips it once per completed sweep.

## Interface
Parameters:
- `Y_BASE`, default 63: first Y SRAM address of a sweep.
- `Y_ROWS`, default 1024: groups per sweep. Legal range is 1..(2048−Y_BASE).

Ports:
- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a sweep. Ignored unless in IDLE.
- `fifo_ready`  in  1  downstream FIFO can accept one issue cycle.
- `y_col_info_0..3`  in  16 each  Y SRAM read data for lanes 0..3. Valid one cycle after `y_rd_en`.
- `y_addr`  out  11  Y SRAM read address.
- `y_rd_en`  out  1  Y SRAM read strobe.
- `sram_addr_port1`  out  36  port-1 address of V SRAM k, at bits [9k+8:9k].
- `sram_addr_port2`  out  36  port-2 address of V SRAM k, same packing.
- `sram_en_port1`  out  4  port-1 read enable, one bit per V SRAM.
- `sram_en_port2`  out  4  port-2 read enable, one bit per V SRAM.
- `lane_issue`  out  4  lane i read granted this cycle.
- `lane_route`  out  12  lane i route at [3i+2:3i] = {port (0=port1, 1=port2), sram[1:0]}.
- `lane_newrow`  out  4  lane i carries a new-row marker.
- `group_last`  out  1  final issue cycle of the current group.
- `busy`  out  1  high in any state other than IDLE.
- `sweep_done`  out  1  one-cycle pulse at the end of a sweep.
- `vsram_bank`  out  1  current V bank bit (address bit 8).

## Operation
Entry decode for lane i:
- newrow = &col[15:13].
- sram = col[1:0].
- addr = {vsram_bank, col[9:2]}. Column bits [12:10] are ignored.

States:
- IDLE: `start` → FETCH, with row counter = 0.
- FETCH: `y_addr` = Y_BASE + row, `y_rd_en` = 1 → LOAD.
- LOAD: capture the four entries. `pending[i]` = !newrow_i. `newrow_reg` = newrow flags. `first` = 1 → ISSUE.
- ISSUE: if `fifo_ready`=0, all enables and `lane_issue` are 0 and state holds. Otherwise arbitrate:
  - Scan pending lanes in order 0→3.
  - Each lane takes port1 of its SRAM if free, else port2 if free, else it waits.
  - Granted lanes clear from `pending`.
  - `lane_newrow` = `newrow_reg` only when `first`=1, then `first` clears.
  - If `pending` is empty after the grant, assert `group_last`. Then: row == Y_ROWS−1 → DONE; else row+1 → FETCH.
  - A group with `pending`=0 at LOAD still spends exactly one ready ISSUE cycle: newrow flags and `group_last` assert, no enables.
- DONE: `sweep_done` = 1, `vsram_bank` toggles → IDLE.

Rules:
- Worst case is two ready ISSUE cycles per group (four lanes on one SRAM).
- ISSUE-phase outputs are decoded combinationally from state, registered lane data and `fifo_ready`. Unused address fields are 0.
- Row counter is 11 bits. `y_addr` wraps modulo 2048; the legal parameter range makes a wrap unreachable.
- `start` outside IDLE has no effect.

## Timing
- Reset: asynchronous. On assertion all registers clear and the state is IDLE. `vsram_bank`=0, `busy`=0, `y_addr`=0, every enable, flag and address output is 0. This holds mid-sweep; there is no resume.
- `start` at cycle 0 → FETCH at cycle 1 (`y_rd_en`=1) → LOAD at 2 → first ISSUE at 3.
- Group throughput with `fifo_ready`=1 is 3 cycles (no conflict) or 4 cycles (conflict).
- `fifo_ready` low inserts cycles only in ISSUE; FETCH and LOAD are never stalled.
- `sweep_done` and the `vsram_bank` toggle fall in the same cycle, the cycle after the last `group_last`. `busy` falls the following cycle.
- `start` coincident with DONE is ignored.

## Test plan
- Distinct SRAMs. Bank 0; lanes are col 0x0014, 0x0019, 0x001E, 0x0023 (SRAM 0,1,2,3; cols 5,6,7,8). Required: one ISSUE cycle, `sram_en_port1`=4'b1111, port1 addresses 5,6,7,8, `group_last`=1.
- Full conflict. All four lanes on SRAM 2. Required:
  - Cycle 1: lanes 0 and 1 on port1/port2, `lane_issue`=4'b0011.
  - Cycle 2: lanes 2 and 3, `lane_issue`=4'b1100, `group_last`=1.
- Newrow. Lane 1 = 0xE000. Required: `lane_newrow`=4'b0010 in the first ISSUE cycle, `lane_issue[1]`=0 throughout. All-newrow group → one cycle, no enables, `group_last`=1.
- Back-pressure. `fifo_ready`=0 for 3 cycles in the conflict case. Required: no enables while low, pending lanes retained; the grant sequence resumes unchanged.
- Sweep. Y_ROWS=2 → `y_addr` 63 then 64, `sweep_done` pulse, `vsram_bank`=1. A second sweep sets address bit 8 to 1 on every read.
- Reset. `reset` asserted during the second ISSUE cycle of a conflict group. Required: all outputs 0 immediately, IDLE, `vsram_bank`=0; a new `start` restarts at `y_addr`=63.
